// File: rtl/run_sequencer.sv
// run_sequencer: drives a processor core through NUM_PROGS back-to-back
// programs. Each program gets a one-cycle core reset, a START_CYCLES start
// pulse, then a RUN phase that counts cycles until dut_ack or TIMEOUT. The
// outcome of each program is reported for one cycle and summed into
// total_cycles.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   go             level request to start a full sequence
//   dut_ack        done/ack from the core, honoured only in RUN
//   dut_reset      one-cycle reset pulse to the core
//   dut_start      START_CYCLES-long start pulse to the core
//   prog_id        program currently selected / last reported
//   busy           sequence in progress
//   result_valid   one-cycle report strobe
//   result_cycles  RUN cycle count of the reported program
//   result_timeout reported program ran out of time
//   total_cycles   saturating sum of result_cycles over the sequence
//   done           sequence complete, held until the next sequence starts
//
// state  | meaning
// IDLE   | waiting for go
// RST    | dut_reset asserted for one cycle
// START  | dut_start asserted, counting down START_CYCLES
// RUN    | counting cycles, waiting for dut_ack or TIMEOUT
// REPORT | result_valid asserted, accumulate total, pick next program
// DONE   | sequence complete, waiting for go to drop

module run_sequencer #(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 4096,
  parameter int NUM_PROGS    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        dut_ack,
  output logic        dut_reset,
  output logic        dut_start,
  output logic [3:0]  prog_id,
  output logic        busy,
  output logic        result_valid,
  output logic [15:0] result_cycles,
  output logic        result_timeout,
  output logic [19:0] total_cycles,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_START, S_RUN, S_REPORT, S_DONE
  } state_t;

  localparam logic [15:0] START_LOAD = 16'(START_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_W  = 16'(TIMEOUT);
  localparam logic [3:0]  LAST_PROG  = 4'(NUM_PROGS - 1);
  localparam logic [19:0] TOTAL_MAX  = '1;

  state_t      state;
  // Shared timer: down-counter in START, up-counter of RUN cycles in RUN.
  logic [15:0] cnt;
  logic [20:0] total_sum;

  assign total_sum = {1'b0, total_cycles} + {5'd0, result_cycles};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      dut_reset      <= 1'b0;
      dut_start      <= 1'b0;
      prog_id        <= '0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
      total_cycles   <= '0;
      done           <= 1'b0;
    end else begin
      // Strobes default low; each state re-asserts what it needs.
      dut_reset    <= 1'b0;
      dut_start    <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state        <= S_RST;
            dut_reset    <= 1'b1;
            busy         <= 1'b1;
            prog_id      <= '0;
            total_cycles <= '0;
            done         <= 1'b0;
          end
        end
        S_RST: begin
          state     <= S_START;
          dut_start <= 1'b1;
          cnt       <= START_LOAD;
        end
        S_START: begin
          if (cnt == '0) begin
            state <= S_RUN;
            cnt   <= 16'd1;
          end else begin
            cnt       <= cnt - 16'd1;
            dut_start <= 1'b1;
          end
        end
        S_RUN: begin
          // Ack wins over a simultaneous timeout.
          if (dut_ack) begin
            state          <= S_REPORT;
            result_valid   <= 1'b1;
            result_cycles  <= cnt;
            result_timeout <= 1'b0;
          end else if (cnt == TIMEOUT_W) begin
            state          <= S_REPORT;
            result_valid   <= 1'b1;
            result_cycles  <= TIMEOUT_W;
            result_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_REPORT: begin
          total_cycles <= total_sum[20] ? TOTAL_MAX : total_sum[19:0];
          if (prog_id == LAST_PROG) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= S_RST;
            prog_id   <= prog_id + 4'd1;
            dut_reset <= 1'b1;
          end
        end
        S_DONE: begin
          if (!go) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer. A main instance (TIMEOUT=40) is exercised with a
// table of sequences, hand-written reset aborts and randomized sequences; a
// second instance (TIMEOUT=8, ack tied low) checks the pure-timeout case.
// Expected per-cycle outputs come from a timeline model: each program lasts
// 1 (RST) + START_CYCLES + run length + 1 (REPORT) cycles.

module tb_run_sequencer;

  localparam int S    = 2;
  localparam int NP   = 3;
  localparam int TO   = 40;
  localparam int TO8  = 8;
  localparam int NVEC = 7;

  logic clk = 1'b0;
  logic reset, go, dut_ack;
  logic ack8 = 1'b0;

  logic        dut_reset, dut_start, busy, result_valid, result_timeout, done;
  logic [3:0]  prog_id;
  logic [15:0] result_cycles;
  logic [19:0] total_cycles;

  logic        r8_dut_reset, r8_dut_start, r8_busy, r8_result_valid, r8_result_timeout, r8_done;
  logic [3:0]  r8_prog_id;
  logic [15:0] r8_result_cycles;
  logic [19:0] r8_total_cycles;

  typedef struct packed {
    logic        dut_reset;
    logic        dut_start;
    logic [3:0]  prog_id;
    logic        busy;
    logic        result_valid;
    logic [15:0] result_cycles;
    logic        result_timeout;
    logic [19:0] total_cycles;
    logic        done;
  } outs_t;

  typedef struct packed {
    logic [NP-1:0][7:0]  acks;
    logic                hold;
    logic [1:0]          stay;
    logic                chk8;
    logic [NP-1:0][15:0] exp_rc;
    logic [NP-1:0]       exp_to;
    logic [19:0]         exp_tot;
  } vec_t;

  outs_t got, got8;
  vec_t  vecs [NVEC];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] lrc = '0;
  logic        lto = 1'b0;

  run_sequencer #(.START_CYCLES(S), .TIMEOUT(TO), .NUM_PROGS(NP)) u_dut (
    .clk(clk), .reset(reset), .go(go), .dut_ack(dut_ack),
    .dut_reset(dut_reset), .dut_start(dut_start), .prog_id(prog_id), .busy(busy),
    .result_valid(result_valid), .result_cycles(result_cycles),
    .result_timeout(result_timeout), .total_cycles(total_cycles), .done(done)
  );

  run_sequencer #(.START_CYCLES(S), .TIMEOUT(TO8), .NUM_PROGS(NP)) u_to8 (
    .clk(clk), .reset(reset), .go(go), .dut_ack(ack8),
    .dut_reset(r8_dut_reset), .dut_start(r8_dut_start), .prog_id(r8_prog_id), .busy(r8_busy),
    .result_valid(r8_result_valid), .result_cycles(r8_result_cycles),
    .result_timeout(r8_result_timeout), .total_cycles(r8_total_cycles), .done(r8_done)
  );

  assign got  = {dut_reset, dut_start, prog_id, busy, result_valid, result_cycles,
                 result_timeout, total_cycles, done};
  assign got8 = {r8_dut_reset, r8_dut_start, r8_prog_id, r8_busy, r8_result_valid,
                 r8_result_cycles, r8_result_timeout, r8_total_cycles, r8_done};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // A program reports the ack cycle if ack arrives within TIMEOUT RUN cycles
  // (0 = never acks), otherwise TIMEOUT with the timeout flag.
  function automatic int run_len(input int timeout, input int a);
    return (a == 0 || a > timeout) ? timeout : a;
  endfunction

  function automatic bit is_to(input int timeout, input int a);
    return (a == 0 || a > timeout);
  endfunction

  function automatic int seq_len(input int timeout, input int acks[NP]);
    int n = 0;
    for (int q = 0; q < NP; q++) n += 2 + S + run_len(timeout, acks[q]);
    return n;
  endfunction

  // 1=RST 2=START 3=RUN (j = RUN cycle) 4=REPORT 0=after the sequence
  function automatic int phase_of(input int t, input int timeout, input int acks[NP],
                                  output int p, output int j);
    int base = 0;
    int len;
    p = 0;
    j = 0;
    for (int q = 0; q < NP; q++) begin
      len = 2 + S + run_len(timeout, acks[q]);
      if (t > base && t <= base + len) begin
        p = q;
        j = t - base - 1 - S;
        if (t - base == 1) return 1;
        if (t - base <= 1 + S) return 2;
        if (t - base < len) return 3;
        return 4;
      end
      base += len;
    end
    return 0;
  endfunction

  // Expected outputs during cycle t of a sequence (t=1 is the first cycle
  // after go is sampled). total_cycles is left unchecked in REPORT cycles.
  function automatic outs_t model_out(input int t, input int timeout, input int acks[NP],
                                      input logic [15:0] lrc_i, input logic lto_i,
                                      output outs_t m);
    outs_t e;
    int    base = 0;
    int    sum = 0;
    int    r, len, o;
    e = '0;
    m = '1;
    e.result_cycles  = lrc_i;
    e.result_timeout = lto_i;
    for (int p = 0; p < NP; p++) begin
      r   = run_len(timeout, acks[p]);
      len = 2 + S + r;
      if (t > base && t <= base + len) begin
        o              = t - base;
        e.busy         = 1'b1;
        e.prog_id      = 4'(p);
        e.total_cycles = 20'(sum);
        if (o == 1) e.dut_reset = 1'b1;
        else if (o <= 1 + S) e.dut_start = 1'b1;
        else if (o == len) begin
          e.result_valid   = 1'b1;
          e.result_cycles  = 16'(r);
          e.result_timeout = is_to(timeout, acks[p]);
          m.total_cycles   = '0;
        end
        return e;
      end
      base += len;
      sum = (sum + r > 1048575) ? 1048575 : sum + r;
      e.result_cycles  = 16'(r);
      e.result_timeout = is_to(timeout, acks[p]);
    end
    e.done         = 1'b1;
    e.prog_id      = 4'(NP - 1);
    e.total_cycles = 20'(sum);
    return e;
  endfunction

  task automatic check_outs(input string name, input int t, input outs_t g, input outs_t e,
                            input outs_t m);
    n_tests++;
    if (((g ^ e) & m) !== '0) begin
      n_fail++;
      $display("FAIL %s cycle %0d: outputs got=%h expected=%h mask=%h", name, t, g, e, m);
    end
  endtask

  task automatic check_val(input string name, input int g, input int e);
    n_tests++;
    if (g != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, g, e);
    end
  endtask

  // Called at the negedge of an IDLE cycle (cycle 0). Runs one sequence,
  // checking every cycle, then stays stay_done extra cycles in DONE with go
  // high, drops go and checks the IDLE cycle. abort_t>0 raises reset in that
  // cycle and returns immediately.
  task automatic run_seq(input string name, input int acks[NP], input bit hold_ack,
                         input bit noise, input int stay_done, input int abort_t,
                         input bit chk8, output int n_rep, output int rc[NP],
                         output bit tm[NP], output int tot);
    int    z[NP];
    int    len, last_t, ph, p, j;
    outs_t e, m, e8, m8;
    for (int q = 0; q < NP; q++) begin
      z[q]  = 0;
      rc[q] = 0;
      tm[q] = 1'b0;
    end
    n_rep   = 0;
    tot     = 0;
    len     = seq_len(TO, acks);
    last_t  = len + 2 + stay_done;
    go      = 1'b1;
    dut_ack = noise ? ($urandom_range(0, 1) == 1) : hold_ack;
    for (int t = 1; t <= last_t; t++) begin
      @(negedge clk);
      e = model_out(t, TO, acks, lrc, lto, m);
      check_outs(name, t, got, e, m);
      if (chk8) begin
        e8 = model_out(t, TO8, z, 16'd0, 1'b0, m8);
        check_outs({name, "_to8"}, t, got8, e8, m8);
      end
      if (got.result_valid && n_rep < NP) begin
        rc[n_rep] = int'(got.result_cycles);
        tm[n_rep] = got.result_timeout;
        n_rep++;
      end
      if (t == len + 1) tot = int'(got.total_cycles);
      if (t == abort_t) begin
        reset   = 1'b1;
        dut_ack = 1'b0;
        return;
      end
      ph = phase_of(t, TO, acks, p, j);
      if (ph == 3) dut_ack = (j == acks[p]);
      else dut_ack = (hold_ack && (ph == 1 || ph == 2)) || (noise && $urandom_range(0, 1) == 1);
      if (t <= len) go = noise ? 1'($urandom_range(0, 1)) : 1'b1;
      else go = (t < len + 1 + stay_done);
    end
    lrc = 16'(run_len(TO, acks[NP-1]));
    lto = is_to(TO, acks[NP-1]);
  endtask

  task automatic set_vec(input int i, input int a0, input int a1, input int a2, input bit h,
                         input int st, input bit c8, input int r0, input int r1, input int r2,
                         input bit t0, input bit t1, input bit t2, input int tot);
    vecs[i].acks[0]   = 8'(a0);
    vecs[i].acks[1]   = 8'(a1);
    vecs[i].acks[2]   = 8'(a2);
    vecs[i].hold      = h;
    vecs[i].stay      = 2'(st);
    vecs[i].chk8      = c8;
    vecs[i].exp_rc[0] = 16'(r0);
    vecs[i].exp_rc[1] = 16'(r1);
    vecs[i].exp_rc[2] = 16'(r2);
    vecs[i].exp_to    = {t2, t1, t0};
    vecs[i].exp_tot   = 20'(tot);
  endtask

  task automatic check_all_zero(input string name);
    check_outs(name, 0, got, '0, '1);
    check_outs({name, "_to8"}, 0, got8, '0, '1);
  endtask

  initial begin
    int a[NP];
    int n_rep, tot;
    int rc[NP];
    bit tm[NP];

    //       idx  acks        hold stay chk8  rc            to       total
    set_vec(0,   0,  0,  0,  0,   2,   1,    40, 40, 40,   1, 1, 1, 120);
    set_vec(1,  10, 20, 30,  0,   0,   0,    10, 20, 30,   0, 0, 0,  60);
    set_vec(2,   1,  1,  1,  1,   1,   0,     1,  1,  1,   0, 0, 0,   3);
    set_vec(3,  40,  1, 39,  0,   0,   0,    40,  1, 39,   0, 0, 0,  80);
    set_vec(4,  41, 40,  2,  0,   1,   0,    40, 40,  2,   1, 0, 0,  82);
    set_vec(5,   3,  1,  2,  1,   3,   0,     3,  1,  2,   0, 0, 0,   6);
    set_vec(6,   7,  0,  5,  0,   0,   0,     7, 40,  5,   0, 1, 0,  52);

    reset   = 1'b1;
    go      = 1'b0;
    dut_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      for (int p = 0; p < NP; p++) a[p] = int'(vecs[i].acks[p]);
      run_seq($sformatf("vec%0d", i), a, vecs[i].hold, 1'b0, int'(vecs[i].stay), 0,
              vecs[i].chk8, n_rep, rc, tm, tot);
      check_val($sformatf("vec%0d_reports", i), n_rep, NP);
      for (int p = 0; p < NP; p++) begin
        check_val($sformatf("vec%0d_cycles%0d", i, p), rc[p], int'(vecs[i].exp_rc[p]));
        check_val($sformatf("vec%0d_timeout%0d", i, p), int'(tm[p]), int'(vecs[i].exp_to[p]));
      end
      check_val($sformatf("vec%0d_total", i), tot, int'(vecs[i].exp_tot));
    end

    // Reset in RUN of program 1, then restart with go still high.
    a = '{10, 20, 30};
    run_seq("abort_run", a, 1'b0, 1'b0, 0, 22, 1'b0, n_rep, rc, tm, tot);
    @(negedge clk);
    check_all_zero("abort_run_zero");
    lrc   = '0;
    lto   = 1'b0;
    reset = 1'b0;
    a = '{5, 6, 7};
    run_seq("after_abort", a, 1'b0, 1'b0, 1, 0, 1'b0, n_rep, rc, tm, tot);
    check_val("after_abort_first", rc[0], 5);

    // Reset in START of program 0.
    a = '{4, 4, 4};
    run_seq("abort_start", a, 1'b0, 1'b0, 0, 3, 1'b0, n_rep, rc, tm, tot);
    @(negedge clk);
    check_all_zero("abort_start_zero");
    lrc   = '0;
    lto   = 1'b0;
    reset = 1'b0;

    // Random ack points, random go toggling while busy, ack noise outside RUN.
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < NP; p++) a[p] = int'($urandom_range(0, 45));
      run_seq($sformatf("rand%0d", k), a, 1'b0, 1'b1, int'($urandom_range(0, 3)), 0, 1'b0,
              n_rep, rc, tm, tot);
      check_val($sformatf("rand%0d_reports", k), n_rep, NP);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
